// File: rtl/jpeg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_cmd_pkg
// Description : Opcodes, command field positions, FSM states and error codes
//               shared by the JPEG command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_cmd_pkg;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int LEN_MSB    = 11;
    localparam int LEN_LSB    = 0;
    localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;

    localparam logic [3:0] OP_DECODE     = 4'h1;
    localparam logic [3:0] OP_SOFT_RESET = 4'h2;
    localparam logic [3:0] OP_STATUS     = 4'h3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_OP   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SRST   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sequencer_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_byte_fifo
// Description : First-word-fall-through byte FIFO with wrap-bit pointers;
//               push while full is accepted only alongside a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer_byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int c_aw = $clog2(FIFO_DEPTH);

    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // On a full push+pop the write lands in the slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/jpeg_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_cmd_sequencer
// Description : Dispatches parser commands, packs payload bits MSB-first into
//               bytes for the decoder and tracks completion and errors.
//               Optional stall watchdog enabled by defining TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_cmd_sequencer
    import jpeg_cmd_pkg::*;
#(
    parameter int COMMAND_WIDTH   = 16,
    parameter int LEN_SHIFT       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int SOFT_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COMMAND_WIDTH-1:0] cmd,
    input  logic                     cmd_valid,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     dec_start,
    output logic                     dec_soft_rst,
    input  logic                     dec_done,
    output logic                     busy,
    output logic                     done,
    output logic                     status_pulse,
    output logic [1:0]               err
);

    localparam int c_rem_w  = LEN_W + LEN_SHIFT + 1;
    localparam int c_srst_w = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;

    state_t              r_state;
    logic [c_rem_w-1:0]  r_remaining;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [c_srst_w-1:0] r_srst_cnt;
    logic                r_done_seen;

    logic [3:0]          w_opcode;
    logic [c_rem_w-1:0]  w_len_bytes;
    logic [7:0]          w_byte;
    logic                w_push_req;
    logic                w_pop;
    logic                w_flush;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [7:0]          w_head;
    logic                w_timeout;

    assign w_opcode    = cmd[OPCODE_MSB:OPCODE_LSB];
    assign w_len_bytes = (c_rem_w'(cmd[LEN_MSB:LEN_LSB]) + c_rem_w'(1)) << LEN_SHIFT;
    assign w_byte      = {r_shift[6:0], bit_in};
    assign w_push_req  = (r_state == ST_STREAM) && bit_valid && (r_bit_cnt == 3'd7);
    assign w_flush     = (r_state == ST_ERROR) || (r_state == ST_SRST);
    assign byte_valid  = !w_fifo_empty && !w_flush;
    assign byte_out    = byte_valid ? w_head : 8'h00;
    assign w_pop       = byte_valid && byte_ready;
    assign busy        = (r_state != ST_IDLE);

    sequencer_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push_req),
        .pop     (w_pop),
        .flush   (w_flush),
        .wr_data (w_byte),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .head    (w_head)
    );

`ifdef TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        w_stalled;

    assign w_stalled = ((r_state == ST_STREAM) && !bit_valid) ||
                       ((r_state == ST_DRAIN) && !w_pop && !r_done_seen && !dec_done);
    assign w_timeout = w_stalled && (r_wdog == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_stalled) r_wdog <= '0;
        else                   r_wdog <= r_wdog + 1'b1;
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_srst_cnt   <= '0;
            r_done_seen  <= 1'b0;
            dec_start    <= 1'b0;
            dec_soft_rst <= 1'b0;
            done         <= 1'b0;
            status_pulse <= 1'b0;
            err          <= ERR_NONE;
        end else begin
            dec_start    <= 1'b0;
            done         <= 1'b0;
            status_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (w_opcode)
                            OP_DECODE: begin
                                r_remaining <= w_len_bytes;
                                r_bit_cnt   <= '0;
                                r_done_seen <= 1'b0;
                                dec_start   <= 1'b1;
                                r_state     <= ST_STREAM;
                            end
                            OP_SOFT_RESET: begin
                                r_srst_cnt   <= '0;
                                dec_soft_rst <= 1'b1;
                                err          <= ERR_NONE;
                                r_state      <= ST_SRST;
                            end
                            OP_STATUS: status_pulse <= 1'b1;
                            default: begin
                                err     <= ERR_BAD_OP;
                                r_state <= ST_ERROR;
                            end
                        endcase
                    end
                end
                ST_SRST: begin
                    if (r_srst_cnt == c_srst_w'(SOFT_RST_CYCLES - 1)) begin
                        dec_soft_rst <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_srst_cnt <= r_srst_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (dec_done) r_done_seen <= 1'b1;
                    if (bit_valid) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_push_req) begin
                            if (w_fifo_full && !w_pop) begin
                                err     <= ERR_OVERFLOW;
                                r_state <= ST_ERROR;
                            end else begin
                                r_remaining <= r_remaining - 1'b1;
                                if (r_remaining == c_rem_w'(1)) r_state <= ST_DRAIN;
                            end
                        end
                    end else if (w_timeout) begin
                        err     <= ERR_TIMEOUT;
                        r_state <= ST_ERROR;
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_empty && (r_done_seen || dec_done)) begin
                        done        <= 1'b1;
                        r_done_seen <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        if (dec_done) r_done_seen <= 1'b1;
                        if (w_timeout) begin
                            err     <= ERR_TIMEOUT;
                            r_state <= ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    if (cmd_valid && (w_opcode == OP_SOFT_RESET)) begin
                        r_srst_cnt   <= '0;
                        dec_soft_rst <= 1'b1;
                        err          <= ERR_NONE;
                        r_state      <= ST_SRST;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_cmd_sequencer
// Description : Self-checking bench for jpeg_cmd_sequencer: command table plus
//               directed streaming, overflow, error and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_cmd_sequencer;

`ifdef TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic        bit_in;
    logic        bit_valid;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        dec_start;
    logic        dec_soft_rst;
    logic        dec_done;
    logic        busy;
    logic        done;
    logic        status_pulse;
    logic [1:0]  err;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  got_q[$];
    int          done_cnt;

    always #5 clk = ~clk;

    jpeg_cmd_sequencer #(
        .COMMAND_WIDTH   (16),
        .LEN_SHIFT       (4),
        .FIFO_DEPTH      (4),
        .SOFT_RST_CYCLES (4),
        .TIMEOUT_CYCLES  (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .dec_start    (dec_start),
        .dec_soft_rst (dec_soft_rst),
        .dec_done     (dec_done),
        .busy         (busy),
        .done         (done),
        .status_pulse (status_pulse),
        .err          (err)
    );

    // Record every accepted byte and every done pulse mid-cycle.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) got_q.push_back(byte_out);
        if (!rst && done) done_cnt++;
    end

    typedef struct {
        logic [15:0] cmd;
        logic        busy;
        logic        start;
        logic        srst;
        logic        status;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd = '0; cmd_valid = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        byte_ready = 1'b0; dec_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ready_on_last);
        for (int i = 7; i >= 0; i--) begin
            bit_in    = b[i];
            bit_valid = 1'b1;
            if (i == 0 && ready_on_last) byte_ready = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " byte_valid"}, byte_valid, 1'b0);
        check({tag, " byte_out"}, byte_out, 8'h00);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " dec_start"}, dec_start, 1'b0);
        check({tag, " dec_soft_rst"}, dec_soft_rst, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " status_pulse"}, status_pulse, 1'b0);
        check({tag, " err"}, err, 2'd0);
    endtask

    task automatic soft_reset_and_count(input string tag);
        int n_high;
        int n_wait;
        send_cmd(16'h2000);
        n_high = 0;
        n_wait = 0;
        while (busy && n_wait < 20) begin
            if (dec_soft_rst) n_high++;
            check({tag, " err cleared"}, err, 2'd0);
            tick();
            n_wait++;
        end
        check({tag, " soft_rst cycles"}, n_high, 4);
        check({tag, " back to idle"}, busy, 1'b0);
    endtask

    initial begin
        int n_found;
        int n_wait;

        vecs[0] = '{cmd: 16'h3000, busy: 1'b0, start: 1'b0, srst: 1'b0, status: 1'b1, err: 2'd0};
        vecs[1] = '{cmd: 16'h1000, busy: 1'b1, start: 1'b1, srst: 1'b0, status: 1'b0, err: 2'd0};
        vecs[2] = '{cmd: 16'h2000, busy: 1'b1, start: 1'b0, srst: 1'b1, status: 1'b0, err: 2'd0};
        vecs[3] = '{cmd: 16'h7123, busy: 1'b1, start: 1'b0, srst: 1'b0, status: 1'b0, err: 2'd1};
        vecs[4] = '{cmd: 16'h0000, busy: 1'b1, start: 1'b0, srst: 1'b0, status: 1'b0, err: 2'd1};
        vecs[5] = '{cmd: 16'hF0FF, busy: 1'b1, start: 1'b0, srst: 1'b0, status: 1'b0, err: 2'd1};
        vecs[6] = '{cmd: 16'h1FFF, busy: 1'b1, start: 1'b1, srst: 1'b0, status: 1'b0, err: 2'd0};

        do_reset();
        check_idle_outputs("reset");

        for (int i = 0; i < 7; i++) begin
            do_reset();
            send_cmd(vecs[i].cmd);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d dec_start", i), dec_start, vecs[i].start);
            check($sformatf("vec%0d dec_soft_rst", i), dec_soft_rst, vecs[i].srst);
            check($sformatf("vec%0d status_pulse", i), status_pulse, vecs[i].status);
            check($sformatf("vec%0d err", i), err, vecs[i].err);
        end

        // STATUS pulse lasts one cycle and never raises busy
        do_reset();
        send_cmd(16'h3000);
        tick();
        check("status one cycle", status_pulse, 1'b0);
        check("status busy low", busy, 1'b0);

        // Full decode: 16 bytes of 0xA5, decoder always ready
        do_reset();
        byte_ready = 1'b1;
        send_cmd(16'h1000);
        check("decode dec_start", dec_start, 1'b1);
        check("decode busy", busy, 1'b1);
        for (int b = 0; b < 16; b++) send_byte(8'hA5, 1'b0);
        check("dec_start cleared", dec_start, 1'b0);
        tick(); tick(); tick();
        check("drain waits for dec_done", busy, 1'b1);
        check("no early done", done_cnt, 0);
        check("decode byte count", got_q.size(), 16);
        for (int b = 0; b < 16 && b < got_q.size(); b++)
            check($sformatf("decode byte%0d", b), got_q[b], 8'hA5);
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        check("done pulse", done, 1'b1);
        check("busy falls", busy, 1'b0);
        tick();
        check("done one cycle", done, 1'b0);
        check("done count", done_cnt, 1);

        // Overflow: decoder stalls, fifth byte has nowhere to go
        do_reset();
        send_cmd(16'h1000);
        for (int b = 0; b < 4; b++) send_byte(8'hA5, 1'b0);
        check("four bytes no err", err, 2'd0);
        send_byte(8'hA5, 1'b0);
        check("overflow err", err, 2'd2);
        check("overflow busy", busy, 1'b1);
        check("overflow byte_valid", byte_valid, 1'b0);
        send_cmd(16'h3000);
        check("status ignored in error", status_pulse, 1'b0);
        check("err held", err, 2'd2);
        soft_reset_and_count("ovf");

        // Bad opcode, then commands other than SOFT_RESET are ignored
        do_reset();
        send_cmd(16'h7123);
        check("bad op err", err, 2'd1);
        send_cmd(16'h3000);
        check("bad op status ignored", status_pulse, 1'b0);
        send_cmd(16'h1000);
        check("bad op decode ignored", dec_start, 1'b0);
        check("bad op err held", err, 2'd1);
        soft_reset_and_count("badop");

        // Full FIFO with a pop in the same cycle as the push; early dec_done
        do_reset();
        send_cmd(16'h1000);
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b0);
        send_byte(8'h05, 1'b1);
        check("full push+pop no err", err, 2'd0);
        check("full push+pop busy", busy, 1'b1);
        for (int b = 6; b <= 16; b++) begin
            send_byte(8'(b), 1'b1);
            if (b == 8) begin
                dec_done = 1'b1;
                tick();
                dec_done = 1'b0;
            end
        end
        n_wait = 0;
        while (!done && n_wait < 20) begin
            tick();
            n_wait++;
        end
        check("early dec_done completes", done, 1'b1);
        tick();
        check("order byte count", got_q.size(), 16);
        for (int b = 0; b < 16 && b < got_q.size(); b++)
            check($sformatf("order byte%0d", b), got_q[b], 8'(b + 1));
        check("order err", err, 2'd0);
        check("order done count", done_cnt, 1);

        // Reset mid-stream discards the partial byte
        do_reset();
        send_cmd(16'h1000);
        send_byte(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        send_cmd(16'h1000);
        send_byte(8'h3C, 1'b0);
        check("post-rst byte_valid", byte_valid, 1'b1);
        check("post-rst byte_out", byte_out, 8'h3C);

`ifdef TIMEOUT_EN
        // Watchdog: stall after three bytes
        do_reset();
        byte_ready = 1'b1;
        send_cmd(16'h1000);
        for (int b = 0; b < 3; b++) send_byte(8'h5A, 1'b0);
        n_found = 0;
        for (int n = 1; n <= 200 && n_found == 0; n++) begin
            tick();
            if (err == 2'd3) n_found = n;
        end
        check("timeout cycles", n_found, 100);
        check("timeout busy", busy, 1'b1);
        check("timeout byte_valid", byte_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("tmo rst");
`else
        n_found = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/jpeg_cmd_sequencer.md
Name: jpeg_cmd_sequencer

Overview:
- Control block between the serial packet front end and the JPEG decoder core.
- Takes the decoded 16-bit command word and the post-command payload bit stream.
- Dispatches opcodes, packs payload bits MSB-first into bytes and buffers them in a small FIFO.
- Feeds the decoder over a valid/ready handshake and tracks completion and errors.

Parameters:
COMMAND_WIDTH, 16, command word width; opcode = cmd[15:12], length field = cmd[11:0]
LEN_SHIFT, 4, payload bytes = (cmd[11:0]+1) << LEN_SHIFT
FIFO_DEPTH, 4, byte FIFO entries (power of two, >=2)
SOFT_RST_CYCLES, 4, length of the dec_soft_rst pulse
TIMEOUT_CYCLES, 65535, stall watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd  in  COMMAND_WIDTH  command word from the parser
cmd_valid  in  1  one-cycle strobe: cmd is new
bit_in  in  1  payload bit
bit_valid  in  1  bit_in is new this cycle
byte_out  out  8  byte to the decoder
byte_valid  out  1  byte_out holds data
byte_ready  in  1  decoder accepts byte_out
dec_start  out  1  one-cycle pulse at the start of a decode
dec_soft_rst  out  1  decoder soft reset
dec_done  in  1  decoder finished image
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a decode completes
status_pulse  out  1  one-cycle pulse on the STATUS opcode
err  out  2  sticky error code: 0 none, 1 bad opcode, 2 FIFO overflow, 3 timeout

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, bit counter 0, byte counter 0, err 0.
- Opcodes: 0x1 DECODE, 0x2 SOFT_RESET, 0x3 STATUS; any other opcode is invalid.
- Register transfer: every registered output changes one cycle after its cause.
- States:
  - IDLE:
    - cmd_valid with DECODE: latch remaining = (len+1)<<LEN_SHIFT, pulse dec_start next cycle, go to STREAM.
    - SOFT_RESET: go to SRST.
    - STATUS: pulse status_pulse, stay in IDLE.
    - Invalid opcode: err=1, go to ERROR.
    - cmd_valid outside IDLE is ignored.
  - SRST: dec_soft_rst held high for exactly SOFT_RST_CYCLES cycles, then IDLE. Clears err.
  - STREAM:
    - Each bit_valid shifts bit_in into an 8-bit register, MSB first.
    - On the 8th bit the byte is pushed to the FIFO in the same cycle; remaining decrements.
    - Push with FIFO full: byte dropped, err=2, go to ERROR.
    - remaining reaching 0 moves to DRAIN; further bits are ignored.
  - DRAIN: wait until the FIFO is empty and dec_done has been seen (dec_done is latched if it arrives early), then pulse done and go to IDLE.
  - ERROR: byte_valid forced 0 and FIFO flushed. Only a SOFT_RESET command leaves ERROR (via SRST). err is held until then.
- FIFO:
  - First-word-fall-through: byte_valid = !empty, byte_out = head entry.
  - A pop occurs on byte_valid & byte_ready.
  - Simultaneous push and pop on a full FIFO is legal and is not an overflow.
  - Pointers are one bit wider than log2(FIFO_DEPTH) and wrap.
- dec_done outside STREAM/DRAIN is ignored.
- rst asserted mid-stream: immediate return to reset values on the next edge; partial byte discarded.

Optional Feature:
TIMEOUT_EN
- Defined:
  - A 16-bit watchdog counts cycles in STREAM with no bit_valid, or in DRAIN with no FIFO pop and no latched dec_done.
  - It resets on any such activity.
  - At TIMEOUT_CYCLES it sets err=3 and moves to ERROR.
- Undefined: no counter logic; err value 3 is never produced.

Decomposition:
- Package jpeg_cmd_pkg:
  - opcode constants (OP_DECODE, OP_SOFT_RESET, OP_STATUS)
  - state encodings
  - error code constants
  - opcode/length field positions
- Sub-module sequencer_byte_fifo (parameter FIFO_DEPTH, 8-bit data):
  - inputs push, pop, flush
  - outputs full, empty, head data

Test Plan:
- DECODE cmd=0x1000 (LEN_SHIFT=4) with 128 bits of 0xA5 pattern and byte_ready=1 -> dec_start one cycle after cmd_valid; 16 bytes 0xA5 out; after dec_done, done pulses once; busy falls.
- Same stream with byte_ready=0 until 5 bytes arrive (FIFO_DEPTH=4) -> err=2, state ERROR, byte_valid=0; then cmd=0x2000 -> dec_soft_rst high for 4 cycles, err=0, IDLE.
- cmd=0x7123 -> err=1, ERROR; cmd=0x3000 while in ERROR is ignored (no status_pulse).
- cmd=0x3000 in IDLE -> status_pulse for one cycle, busy stays 0.
- FIFO full with byte_ready=1 and 8th bit arriving in the same cycle -> no overflow, byte order preserved.
- With TIMEOUT_EN and TIMEOUT_CYCLES=100: DECODE, then stop bits after 3 bytes -> err=3 exactly 100 cycles after the last bit; rst mid-stream returns all outputs to 0.
